gstmcu_ram_sched: RTL and testbench
===================================

Name: gstmcu_ram_sched

Overview:
- DRAM slot scheduler for the GSTMCU.
- Time-slices the shared video RAM into fixed 4-clock slots and grants each slot to one of four owners: video fetch, refresh, DMA or CPU.
- Owns the video address counter, which is reloaded on vsync and advanced per video fetch.
- Sits beside the sync/DE generators, consumes their `de`/`vsync_n`, and drives the RAM address/strobe datapath.

Parameters:
- ADDR_W, 21, word-address width of all address ports.
- REFRESH_PERIOD, 64, slots between refresh requests (must be ≥2).
- SPARE_EN, 1, 1 = even slots not used by video/refresh may be given to DMA/CPU.

Ports:
- m2clock  in  1  system clock; one slot = 4 cycles.
- res  in  1  synchronous active-high reset.
- de  in  1  display enable from timing generator.
- vsync_n  in  1  active-low vertical sync.
- vid_base  in  ADDR_W  screen base word address.
- dma_req  in  1  DMA access request, held until dma_ack.
- dma_addr  in  ADDR_W  DMA word address.
- dma_ack  out  1  one-cycle pulse, DMA slot completed.
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_ack  out  1  one-cycle pulse, CPU slot completed.
- vid_load  out  1  one-cycle pulse, video word fetched.
- vid_addr  out  ADDR_W  current video fetch address.
- ram_cycle  out  1  one-cycle strobe at start of a non-idle slot.
- ram_refresh  out  1  high for whole refresh slot.
- ram_addr  out  ADDR_W  address of current slot owner, held entire slot.
- ram_owner  out  3  current owner code.

Behaviour:

Reset:
- res sampled on the m2clock rising edge.
- Forces: phase=0, slot parity=even, owner=IDLE, vid_addr=0, refresh counter=0, ref_pend=0.
- All outputs 0.
- Reset mid-slot aborts the slot: no ack, no vid_load.

Phase and slot timing:
- Phase counter ph counts 0..3 continuously.
- Slot parity toggles when ph wraps 3→0.
- Owner for the next slot is decided at ph==3 and registered on the 3→0 edge. The first slot after reset is therefore IDLE.

Even-slot priority:
1. VIDEO if de=1 at the decision cycle.
2. REFRESH if ref_pend>0.
3. If SPARE_EN: DMA if dma_req, else CPU if cpu_req.
4. Otherwise IDLE.

Odd-slot priority:
1. DMA if dma_req.
2. CPU if cpu_req.
3. Otherwise IDLE.

No request is ever granted two consecutive slots unless re-requested after its ack. Because the ack is issued at ph==3 of the granted slot (see below), a requester holding req across its ack is not eligible for the slot decided in that same cycle.

Slot outputs:
- ram_cycle=1 at ph==0 of every non-IDLE slot.
- ram_owner and ram_addr are stable for ph 0..3.
- ram_addr source: vid_addr for VIDEO, dma_addr or cpu_addr (captured at grant) for DMA/CPU, 0 for REFRESH and IDLE.
- ram_refresh=1 for the whole REFRESH slot.

Completion (all at ph==3 of the granted slot):
- dma_ack / cpu_ack pulse for one cycle.
- vid_load pulses for one cycle and vid_addr increments by 1, wrapping modulo 2^ADDR_W.
- ref_pend decrements at ph==3 of a REFRESH slot.

Refresh request generation:
- Refresh counter counts slots. Every REFRESH_PERIOD slots it increments ref_pend, which saturates at 3.
- If an increment and a decrement fall in the same cycle, ref_pend is unchanged.

Vsync reload:
- vsync_n is registered; its falling edge is detected from the registered value.
- One cycle after detection, vid_addr<=vid_base.
- If the reload coincides with a video increment, the reload wins.
- A video slot already granted keeps the address it latched at ph==0.

Protocol rules:
- A requester dropping req after grant still receives its ack; the slot completes normally.
- Address changes after grant are ignored.

Decomposition:
- Package gstmcu_pkg holds:
  - owner enum: IDLE=0, VIDEO=1, REFRESH=2, DMA=3, CPU=4;
  - phase constants PH_START=0, PH_DECIDE=3;
  - SLOT_LEN=4.
- One natural sub-module, gstmcu_vid_addr_cnt: vsync edge detect, reload and increment. Arbitration and phase logic stay in the top module.

Test Plan:
- Reset release, all requests low, de=0 → ram_owner=0 and ram_cycle=0 for 2 slots; first refresh at slot 64 produces ram_refresh high for 4 cycles, ram_owner=2.
- vid_base=0x1000, vsync_n pulse low, then de=1 for 16 slots → 8 vid_load pulses at ph==3 of even slots; ram_addr on those slots 0x1000..0x1007; vid_addr ends at 0x1008.
- dma_req and cpu_req both held, de=1 → odd slots alternate DMA then CPU: dma_ack first at ph==3 of the first odd slot, cpu_ack at the next odd slot; no grant to either in even slots.
- de=1 continuously for 200 slots with REFRESH_PERIOD=64 → ref_pend saturates at 3. After de drops, exactly 3 REFRESH even slots follow and ref_pend returns to 0.
- vsync_n falling edge timed so the reload lands on the same cycle as a vid_load increment → vid_addr = vid_base, not vid_base+1.
- res asserted at ph==2 of a CPU slot → no cpu_ack, all outputs 0 on the next cycle; with cpu_req still held after release, the request is granted in the first odd slot and acked once.

Source files
------------

// File: rtl/gstmcu_pkg.sv
// gstmcu_pkg: shared definitions for the GSTMCU DRAM slot scheduler.
//   owner_t       slot owner codes, as driven on ram_owner
//   SLOT_LEN      clocks per RAM slot
//   ph_t          phase counter type (0..SLOT_LEN-1)
//   PH_START      first phase of a slot (owner/address become valid)
//   PH_DECIDE     last phase of a slot (next owner chosen, completions pulse)
//   REF_PEND_MAX  saturation value of the pending-refresh counter
package gstmcu_pkg;

  localparam int SLOT_LEN = 4;

  typedef logic [$clog2(SLOT_LEN)-1:0] ph_t;

  localparam ph_t PH_START  = ph_t'(0);
  localparam ph_t PH_DECIDE = ph_t'(3);

  localparam logic [1:0] REF_PEND_MAX = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VIDEO   = 3'd1,
    REFRESH = 3'd2,
    DMA     = 3'd3,
    CPU     = 3'd4
  } owner_t;

endpackage

// File: rtl/gstmcu_ram_sched_if.sv
// gstmcu_ram_sched_if: bus between the RAM slot scheduler and its neighbours.
//   de, vsync_n           timing generator inputs
//   vid_base              screen base word address
//   dma_req/addr/ack      DMA request handshake (req held until ack)
//   cpu_req/addr/ack      CPU request handshake (req held until ack)
//   vid_load, vid_addr    video fetch pulse and current fetch address
//   ram_cycle             strobe at the start of each non-idle slot
//   ram_refresh           high for a whole refresh slot
//   ram_addr, ram_owner   address and owner of the current slot
// Modport slave is the scheduler side; master is the environment side.
interface gstmcu_ram_sched_if #(
  parameter int ADDR_W = 21
) ();

  logic              de;
  logic              vsync_n;
  logic [ADDR_W-1:0] vid_base;
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_ack;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic              vid_load;
  logic [ADDR_W-1:0] vid_addr;
  logic              ram_cycle;
  logic              ram_refresh;
  logic [ADDR_W-1:0] ram_addr;
  logic [2:0]        ram_owner;

  modport master (
    output de, vsync_n, vid_base, dma_req, dma_addr, cpu_req, cpu_addr,
    input  dma_ack, cpu_ack, vid_load, vid_addr,
           ram_cycle, ram_refresh, ram_addr, ram_owner
  );

  modport slave (
    input  de, vsync_n, vid_base, dma_req, dma_addr, cpu_req, cpu_addr,
    output dma_ack, cpu_ack, vid_load, vid_addr,
           ram_cycle, ram_refresh, ram_addr, ram_owner
  );

endinterface

// File: rtl/gstmcu_vid_addr_cnt.sv
// gstmcu_vid_addr_cnt: video fetch address counter.
//   clk, rst    system clock, synchronous active-high reset
//   vsync_n     active-low vertical sync (asynchronous to nothing, just registered)
//   vid_base    value loaded one cycle after a vsync falling edge is seen
//   inc         advance the address by one word (modulo 2^ADDR_W)
//   vid_addr    current video fetch address
// A reload takes precedence over a simultaneous increment.
module gstmcu_vid_addr_cnt #(
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync_n,
  input  logic [ADDR_W-1:0] vid_base,
  input  logic              inc,
  output logic [ADDR_W-1:0] vid_addr
);

  logic vsync_n_p1;
  logic vsync_n_p2;
  logic reload_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Sync registers idle high so reset release never looks like an edge.
      vsync_n_p1 <= 1'b1;
      vsync_n_p2 <= 1'b1;
      reload_p3  <= 1'b0;
      vid_addr   <= '0;
    end else begin
      // p1/p2: registered vsync_n and its delayed copy for edge detection
      vsync_n_p1 <= vsync_n;
      vsync_n_p2 <= vsync_n_p1;
      // p3: falling edge seen on the registered value, reload next edge
      reload_p3  <= vsync_n_p2 & ~vsync_n_p1;
      if (reload_p3) begin
        vid_addr <= vid_base;
      end else if (inc) begin
        vid_addr <= vid_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/gstmcu_ram_sched.sv
// gstmcu_ram_sched: DRAM slot scheduler for the GSTMCU.
//   m2clock   system clock; one RAM slot lasts SLOT_LEN cycles
//   res       synchronous active-high reset
//   bus       gstmcu_ram_sched_if.slave (requests in, slot strobes out)
// The RAM is time-sliced into slots alternating even/odd. Even slots go to
// video, then refresh, then (with SPARE_EN) DMA/CPU; odd slots go to DMA,
// then CPU. The next owner is chosen in the last phase of a slot and takes
// over on the following edge; completions pulse in the last phase of the
// granted slot.
module gstmcu_ram_sched
  import gstmcu_pkg::*;
#(
  parameter int ADDR_W         = 21,
  parameter int REFRESH_PERIOD = 64,
  parameter bit SPARE_EN       = 1'b1
) (
  input logic               m2clock,
  input logic               res,
  gstmcu_ram_sched_if.slave bus
);

  localparam int  RC_W   = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
  localparam ph_t PH_PRE = PH_DECIDE - ph_t'(1);

  ph_t               ph;
  logic              slot_odd;
  owner_t            owner;
  logic [ADDR_W-1:0] slot_addr;
  logic [RC_W-1:0]   ref_cnt;
  logic [1:0]        ref_pend;
  logic              dma_served;
  logic              cpu_served;
  logic              ram_cycle_r;
  logic              dma_ack_r;
  logic              cpu_ack_r;
  logic              vid_load_r;
  logic [ADDR_W-1:0] vid_addr;

  owner_t            next_owner;
  logic [ADDR_W-1:0] next_addr;
  logic              dma_elig;
  logic              cpu_elig;
  logic              ref_inc;
  logic              ref_dec;

  gstmcu_vid_addr_cnt #(
    .ADDR_W(ADDR_W)
  ) u_vid_addr_cnt (
    .clk      (m2clock),
    .rst      (res),
    .vsync_n  (bus.vsync_n),
    .vid_base (bus.vid_base),
    .inc      (vid_load_r),
    .vid_addr (vid_addr)
  );

  // A requester that keeps req high across its ack stays locked out until it
  // drops req; the ack term covers the decision taken in the ack cycle itself,
  // before the served flag has been set.
  always_comb begin
    dma_elig   = bus.dma_req & ~dma_served & ~dma_ack_r;
    cpu_elig   = bus.cpu_req & ~cpu_served & ~cpu_ack_r;
    next_owner = IDLE;
    next_addr  = '0;
    if (slot_odd) begin
      // Current slot is odd, so the one being decided is even.
      if (bus.de) begin
        next_owner = VIDEO;
        next_addr  = vid_addr;
      end else if (ref_pend != 2'd0) begin
        next_owner = REFRESH;
      end else if (SPARE_EN && dma_elig) begin
        next_owner = DMA;
        next_addr  = bus.dma_addr;
      end else if (SPARE_EN && cpu_elig) begin
        next_owner = CPU;
        next_addr  = bus.cpu_addr;
      end
    end else begin
      if (dma_elig) begin
        next_owner = DMA;
        next_addr  = bus.dma_addr;
      end else if (cpu_elig) begin
        next_owner = CPU;
        next_addr  = bus.cpu_addr;
      end
    end
  end

  // Refresh bookkeeping happens on slot boundaries. The request is raised one
  // slot early so it is already pending when the REFRESH_PERIOD-th slot is
  // decided.
  assign ref_inc = (ph == PH_DECIDE) && (ref_cnt == RC_W'(REFRESH_PERIOD - 2));
  assign ref_dec = (ph == PH_DECIDE) && (owner == REFRESH);

  always_ff @(posedge m2clock) begin
    if (res) begin
      ph          <= PH_START;
      slot_odd    <= 1'b0;
      owner       <= IDLE;
      slot_addr   <= '0;
      ref_cnt     <= '0;
      ref_pend    <= 2'd0;
      dma_served  <= 1'b0;
      cpu_served  <= 1'b0;
      ram_cycle_r <= 1'b0;
      dma_ack_r   <= 1'b0;
      cpu_ack_r   <= 1'b0;
      vid_load_r  <= 1'b0;
    end else begin
      ph          <= ph + ph_t'(1);
      ram_cycle_r <= 1'b0;

      // Completion pulses land in the last phase of the granted slot.
      dma_ack_r  <= (ph == PH_PRE) && (owner == DMA);
      cpu_ack_r  <= (ph == PH_PRE) && (owner == CPU);
      vid_load_r <= (ph == PH_PRE) && (owner == VIDEO);

      // Slot boundary: hand the RAM to the next owner.
      if (ph == PH_DECIDE) begin
        owner       <= next_owner;
        slot_addr   <= next_addr;
        ram_cycle_r <= (next_owner != IDLE);
        slot_odd    <= ~slot_odd;
        ref_cnt     <= (ref_cnt == RC_W'(REFRESH_PERIOD - 1)) ? '0 : ref_cnt + RC_W'(1);
      end

      if (ref_inc && !ref_dec) begin
        if (ref_pend != REF_PEND_MAX) begin
          ref_pend <= ref_pend + 2'd1;
        end
      end else if (ref_dec && !ref_inc) begin
        ref_pend <= ref_pend - 2'd1;
      end

      if (!bus.dma_req) begin
        dma_served <= 1'b0;
      end else if (dma_ack_r) begin
        dma_served <= 1'b1;
      end
      if (!bus.cpu_req) begin
        cpu_served <= 1'b0;
      end else if (cpu_ack_r) begin
        cpu_served <= 1'b1;
      end
    end
  end

  assign bus.ram_owner   = owner;
  assign bus.ram_addr    = slot_addr;
  assign bus.ram_cycle   = ram_cycle_r;
  assign bus.ram_refresh = (owner == REFRESH);
  assign bus.dma_ack     = dma_ack_r;
  assign bus.cpu_ack     = cpu_ack_r;
  assign bus.vid_load    = vid_load_r;
  assign bus.vid_addr    = vid_addr;

endmodule

// File: tb/tb_gstmcu_ram_sched.sv
// tb_gstmcu_ram_sched: directed bench for the GSTMCU RAM slot scheduler.
// Time is tracked as tcyc = cycles since reset release; the cycle with
// tcyc = 4*s + p is phase p of slot s. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_gstmcu_ram_sched;
  import gstmcu_pkg::*;

  localparam int ADDR_W = 21;

  logic m2clock = 1'b0;
  logic res     = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   tcyc    = 0;

  always #5 m2clock = ~m2clock;

  gstmcu_ram_sched_if #(.ADDR_W(ADDR_W)) bus ();

  gstmcu_ram_sched #(
    .ADDR_W         (ADDR_W),
    .REFRESH_PERIOD (64),
    .SPARE_EN       (1'b1)
  ) dut (
    .m2clock (m2clock),
    .res     (res),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at tcyc %0d: got %0h expected %0h", tag, tcyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge m2clock);
    tcyc++;
    @(negedge m2clock);
  endtask

  task automatic goto_cyc(input int n);
    while (tcyc < n) step();
  endtask

  task automatic clear_inputs();
    bus.de       = 1'b0;
    bus.vsync_n  = 1'b1;
    bus.vid_base = '0;
    bus.dma_req  = 1'b0;
    bus.dma_addr = '0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
  endtask

  // Ends at the falling edge of slot 0 phase 0 with res already low.
  task automatic do_reset();
    @(negedge m2clock);
    res = 1'b1;
    @(posedge m2clock);
    @(posedge m2clock);
    @(negedge m2clock);
    res  = 1'b0;
    tcyc = 0;
  endtask

  int n_a, n_b, n_c;

  initial begin
    clear_inputs();

    // ---- 1: reset state, idle slots, first refresh at slot 64 ----
    do_reset();
    chk("rst_vid_addr", bus.vid_addr, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_refresh", bus.ram_refresh, 0);
    chk("rst_acks", {bus.dma_ack, bus.cpu_ack, bus.vid_load}, 0);
    for (int i = 0; i < 8; i++) begin
      goto_cyc(i);
      chk("idle_owner", bus.ram_owner, IDLE);
      chk("idle_cycle", bus.ram_cycle, 0);
    end
    goto_cyc(4 * 63);
    chk("pre_ref_refresh", bus.ram_refresh, 0);
    goto_cyc(4 * 64);
    chk("ref_owner", bus.ram_owner, REFRESH);
    chk("ref_cycle", bus.ram_cycle, 1);
    chk("ref_addr", bus.ram_addr, 0);
    for (int p = 0; p < 4; p++) begin
      goto_cyc(4 * 64 + p);
      chk("ref_high", bus.ram_refresh, 1);
    end
    goto_cyc(4 * 65);
    chk("ref_end", bus.ram_refresh, 0);

    // ---- 2: vsync reload then 8 video fetches ----
    clear_inputs();
    do_reset();
    bus.vid_base = 21'h1000;
    bus.vsync_n  = 1'b0;
    step();
    bus.vsync_n  = 1'b1;
    goto_cyc(4);
    bus.de = 1'b1;
    n_a = 0;
    n_b = 0;
    while (tcyc < 4 * 20) begin
      if (tcyc == 4 * 17) bus.de = 1'b0;
      if (bus.vid_load) begin
        n_a++;
        if (!(tcyc % 4 == 3 && (tcyc / 4) % 2 == 0)) n_b++;
      end
      if (tcyc % 8 == 0 && tcyc >= 8 && tcyc <= 64) begin
        chk("vid_owner", bus.ram_owner, VIDEO);
        chk("vid_ram_addr", bus.ram_addr, 32'h1000 + (tcyc / 8 - 1));
      end
      step();
    end
    chk("vid_load_count", n_a, 8);
    chk("vid_load_misplaced", n_b, 0);
    chk("vid_addr_end", bus.vid_addr, 32'h1008);

    // ---- 3: DMA/CPU in odd slots, lockout while held, re-request ----
    clear_inputs();
    do_reset();
    bus.de       = 1'b1;
    bus.dma_req  = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.dma_addr = 21'h0AAA;
    bus.cpu_addr = 21'h0BBB;
    n_a = 0;
    n_b = 0;
    n_c = 0;
    while (tcyc < 24) begin
      if (tcyc == 5) bus.dma_addr = 21'h0CCC;
      if (bus.dma_ack) n_a++;
      if (bus.cpu_ack) n_b++;
      if ((bus.ram_owner == DMA || bus.ram_owner == CPU) && (tcyc / 4) % 2 == 0) n_c++;
      if (tcyc == 4) begin
        chk("dma_owner", bus.ram_owner, DMA);
        chk("dma_cycle", bus.ram_cycle, 1);
      end
      if (tcyc == 6) chk("dma_addr_held", bus.ram_addr, 32'h0AAA);
      if (tcyc == 7) chk("dma_ack_time", bus.dma_ack, 1);
      if (tcyc == 12) begin
        chk("cpu_owner", bus.ram_owner, CPU);
        chk("cpu_addr", bus.ram_addr, 32'h0BBB);
      end
      if (tcyc == 15) chk("cpu_ack_time", bus.cpu_ack, 1);
      if (tcyc == 20) chk("held_locked_out", bus.ram_owner, IDLE);
      step();
    end
    chk("dma_ack_count", n_a, 1);
    chk("cpu_ack_count", n_b, 1);
    chk("even_slot_grants", n_c, 0);
    bus.dma_req = 1'b0;
    step();
    bus.dma_req = 1'b1;
    goto_cyc(28);
    chk("dma_rereq_owner", bus.ram_owner, DMA);
    chk("dma_rereq_addr", bus.ram_addr, 32'h0CCC);
    goto_cyc(31);
    chk("dma_rereq_ack", bus.dma_ack, 1);

    // ---- 4: refresh pending saturates at 3 while video owns even slots ----
    clear_inputs();
    do_reset();
    bus.de = 1'b1;
    n_a = 0;
    while (tcyc < 4 * 270) begin
      if (bus.ram_refresh) n_a++;
      step();
    end
    chk("no_ref_during_video", n_a, 0);
    bus.de = 1'b0;
    n_a = 0;
    n_b = 0;
    while (tcyc < 4 * 300) begin
      if (bus.ram_refresh) n_a++;
      if (bus.ram_refresh && tcyc % 4 == 0) n_b++;
      if (tcyc == 4 * 272) chk("ref_sat_first", bus.ram_owner, REFRESH);
      if (tcyc == 4 * 278) chk("ref_drained", bus.ram_owner, IDLE);
      step();
    end
    chk("ref_sat_slots", n_b, 3);
    chk("ref_sat_cycles", n_a, 12);

    // ---- 5: vsync reload coinciding with a video increment ----
    clear_inputs();
    do_reset();
    bus.de       = 1'b1;
    bus.vid_base = 21'h2000;
    goto_cyc(16);
    chk("coin_slot4_addr", bus.ram_addr, 1);
    goto_cyc(17);
    bus.vsync_n = 1'b0;
    step();
    bus.vsync_n = 1'b1;
    goto_cyc(19);
    chk("coin_vid_load", bus.vid_load, 1);
    goto_cyc(20);
    chk("coin_reload_wins", bus.vid_addr, 32'h2000);
    goto_cyc(24);
    chk("coin_next_slot", bus.ram_addr, 32'h2000);
    goto_cyc(28);
    chk("coin_after_inc", bus.vid_addr, 32'h2001);

    // ---- 6: reset in the middle of a CPU slot ----
    clear_inputs();
    do_reset();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 21'h0123;
    goto_cyc(4);
    chk("mid_cpu_owner", bus.ram_owner, CPU);
    goto_cyc(6);
    res = 1'b1;
    @(posedge m2clock);
    @(negedge m2clock);
    chk("mid_rst_cpu_ack", bus.cpu_ack, 0);
    chk("mid_rst_owner", bus.ram_owner, IDLE);
    chk("mid_rst_addr", bus.ram_addr, 0);
    chk("mid_rst_misc", {bus.ram_cycle, bus.ram_refresh, bus.dma_ack, bus.vid_load}, 0);
    @(posedge m2clock);
    @(negedge m2clock);
    res  = 1'b0;
    tcyc = 0;
    n_a  = 0;
    while (tcyc < 24) begin
      if (bus.cpu_ack) n_a++;
      if (tcyc == 4) begin
        chk("post_rst_owner", bus.ram_owner, CPU);
        chk("post_rst_addr", bus.ram_addr, 32'h0123);
      end
      if (tcyc == 7) chk("post_rst_ack", bus.cpu_ack, 1);
      step();
    end
    chk("post_rst_ack_count", n_a, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
